// File: rtl/rr_onehot_arb.sv
// Round-robin arbiter with a one-hot grant, a binary grant index and a hold limit.
// Ports: clk, rst_n (sync), req[O_w], done -> gnt[O_w], gnt_idx, gnt_vld, timeout.
module rr_onehot_arb #(
  parameter int Bin_w    = 4,
  parameter int O_w      = 2**Bin_w,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [O_w-1:0]   req,
  input  logic             done,
  output logic [O_w-1:0]   gnt,
  output logic [Bin_w-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state;
  logic [Bin_w-1:0] ptr;
  logic [7:0]       hold_cnt;

  logic             found;
  logic [Bin_w-1:0] win;
  logic             hold_hit;
  logic             req_cur;
  logic             rel;
  logic [Bin_w-1:0] ptr_nxt;

  // First set request at or above ptr, wrapping at O_w-1.
  always_comb begin
    int unsigned j;
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int i = 0; i < O_w; i++) begin
      j = (int'(ptr) + i) % O_w;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = Bin_w'(j);
      end
    end
  end

  assign hold_hit = (hold_cnt == 8'(MAX_HOLD));
  assign req_cur  = req[gnt_idx];
  assign rel      = done | ~req_cur | hold_hit;
  assign ptr_nxt  = (gnt_idx == Bin_w'(O_w - 1)) ?
                    '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (found) begin
            state    <= GRANT;
            gnt      <= O_w'(1) << win;
            gnt_idx  <= win;
            gnt_vld  <= 1'b1;
            hold_cnt <= 8'd1;
          end
        end
        GRANT: begin
          if (rel) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_idx  <= '0;
            gnt_vld  <= 1'b0;
            hold_cnt <= '0;
            ptr      <= ptr_nxt;
            // Only a pure hold-limit release is a timeout.
            timeout  <= hold_hit & ~done & req_cur;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_onehot_arb.sv
// Testbench for rr_onehot_arb: directed scenarios plus random traffic
// checked against a behavioural arbiter model.
module tb_rr_onehot_arb;

  localparam int BW = 4;
  localparam int N  = 16;
  localparam int MH = 8;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          done;
  logic [N-1:0]  gnt;
  logic [BW-1:0] gnt_idx;
  logic          gnt_vld;
  logic          timeout;

  rr_onehot_arb #(.Bin_w(BW), .O_w(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nassert = 0;
  int nfail   = 0;

  // model: who holds the resource, for how long, where the search starts
  bit m_busy;
  int m_holder;
  int m_cycles;
  int m_start;
  bit m_to;

  // fairness bookkeeping from the DUT's own grants
  int  waits[N];
  bit  prev_vld;
  int  max_wait;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic d,
                            input logic rn);
    if (!rn) begin
      m_busy = 0; m_holder = 0; m_cycles = 0; m_start = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      for (int k = 0; k < N; k++) begin
        if (!m_busy && r[(m_start + k) % N]) begin
          m_busy   = 1;
          m_holder = (m_start + k) % N;
          m_cycles = 1;
        end
      end
    end else if (d || !r[m_holder] || m_cycles == MH) begin
      m_to     = (m_cycles == MH) && !d && r[m_holder];
      m_busy   = 0;
      m_start  = (m_holder + 1) % N;
      m_cycles = 0;
    end else begin
      m_cycles = m_cycles + 1;
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic d,
                      input logic rn);
    req = r; done = d; rst_n = rn;
    @(posedge clk);
    model_edge(r, d, rn);
    #1;
    chk("gnt", 32'(gnt), m_busy ? (32'd1 << m_holder) : 32'd0);
    chk("gnt_idx", 32'(gnt_idx), m_busy ? 32'(m_holder) : 32'd0);
    chk("gnt_vld", 32'(gnt_vld), 32'(m_busy));
    chk("timeout", 32'(timeout), 32'(m_to));
    if (gnt_vld && !prev_vld) begin
      for (int i = 0; i < N; i++) begin
        if (i == int'(gnt_idx) || !r[i]) waits[i] = 0;
        else waits[i] = waits[i] + 1;
        if (waits[i] > max_wait) max_wait = waits[i];
      end
    end
    for (int i = 0; i < N; i++) if (!r[i]) waits[i] = 0;
    prev_vld = gnt_vld;
  endtask

  task automatic do_reset();
    step('0, 1'b0, 1'b0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);
  endtask

  logic [N-1:0] rr;
  logic         dd;

  initial begin
    req = '0; done = 1'b0; rst_n = 1'b0;
    m_busy = 0; m_holder = 0; m_cycles = 0; m_start = 0; m_to = 0;
    prev_vld = 0; max_wait = 0;
    for (int i = 0; i < N; i++) waits[i] = 0;

    do_reset();
    step('0, 1'b0, 1'b1);
    chk("idle_vld", 32'(gnt_vld), 32'd0);

    // alternating pair 0 / 4 with done after two grant cycles
    for (int g = 0; g < 4; g++) begin
      step(16'h0011, 1'b0, 1'b1);
      chk("pair_idx", 32'(gnt_idx), (g % 2 == 0) ? 32'd0 : 32'd4);
      step(16'h0011, 1'b0, 1'b1);
      step(16'h0011, 1'b1, 1'b1);
      chk("pair_bubble", 32'(gnt_vld), 32'd0);
    end

    // wrap from requester 15 back to 0
    do_reset();
    step(16'h8000, 1'b0, 1'b1);
    chk("wrap_15", 32'(gnt_idx), 32'd15);
    step(16'h8000, 1'b1, 1'b1);
    step(16'h8001, 1'b0, 1'b1);
    chk("wrap_gnt", 32'(gnt), 32'h0001);
    chk("wrap_idx", 32'(gnt_idx), 32'd0);

    // hold limit produces a timeout pulse
    do_reset();
    for (int c = 0; c < MH; c++) begin
      step(16'h0004, 1'b0, 1'b1);
      chk("hold_gnt", 32'(gnt), 32'h0004);
    end
    step(16'h0004, 1'b0, 1'b1);
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_gnt", 32'(gnt), 32'd0);
    step(16'h0004, 1'b0, 1'b1);
    chk("to_regrant", 32'(gnt), 32'h0004);
    chk("to_clear", 32'(timeout), 32'd0);

    // done in the last allowed cycle suppresses timeout
    do_reset();
    for (int c = 0; c < MH; c++) step(16'h0004, 1'b0, 1'b1);
    step(16'h0004, 1'b1, 1'b1);
    chk("sim_to", 32'(timeout), 32'd0);
    chk("sim_gnt", 32'(gnt), 32'd0);

    // reset in the middle of a grant
    do_reset();
    step(16'h0040, 1'b0, 1'b1);
    chk("mid_gnt", 32'(gnt), 32'h0040);
    step(16'h0040, 1'b0, 1'b1);
    step(16'h00C0, 1'b0, 1'b0);
    chk("mid_rst", 32'(gnt), 32'd0);
    step(16'h00C0, 1'b0, 1'b1);
    chk("mid_next", 32'(gnt_idx), 32'd6);

    // random traffic with invariant and fairness checks
    do_reset();
    prev_vld = 0; max_wait = 0;
    for (int i = 0; i < N; i++) waits[i] = 0;
    rr = N'($urandom);
    for (int c = 0; c < 1000; c++) begin
      if ($urandom_range(0, 3) == 0)
        rr = rr ^ (N'(1) << $urandom_range(0, N - 1));
      if ($urandom_range(0, 49) == 0) rr = '0;
      dd = ($urandom_range(0, 4) == 0);
      step(rr, dd, 1'b1);
      chk("rnd_onehot", 32'($onehot0(gnt)), 32'd1);
      chk("rnd_vld", 32'(gnt_vld), 32'(|gnt));
      if (gnt_vld)
        chk("rnd_shift", 32'(gnt), 32'd1 << gnt_idx);
    end
    chk("fairness", 32'(max_wait <= N), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule
